// File: rtl/mulu_seq_stream_pkg.sv
// Shared types and elaboration-time helpers for the streaming sequential multiplier.
package mulu_seq_stream_pkg;

    typedef enum logic [2:0] {
        LOAD_M,
        LOAD_Q,
        CALC,
        FIXUP,
        EMIT
    } state_t;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    // Bits needed to count 0..v-1, never less than one.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic int unsigned calc_p_w(input int unsigned m_w, input int unsigned q_w);
        return m_w + q_w;
    endfunction

    function automatic int unsigned calc_nm(input int unsigned m_w, input int unsigned in_w);
        return ceil_div(m_w, in_w);
    endfunction

    function automatic int unsigned calc_nq(input int unsigned q_w, input int unsigned in_w);
        return ceil_div(q_w, in_w);
    endfunction

    function automatic int unsigned calc_np(input int unsigned p_w, input int unsigned out_w);
        return ceil_div(p_w, out_w);
    endfunction

endpackage

// File: rtl/mulu_seq_stream_datapath.sv
// Operand assembly, magnitude conversion, shift-add accumulation, sign fix-up
// and the output chunk shift register.
module mulu_seq_datapath
    import mulu_seq_stream_pkg::*;
#(
    parameter int unsigned M_WIDTH = 7,
    parameter int unsigned Q_WIDTH = 7,
    parameter int unsigned IN_W    = 6,
    parameter int unsigned OUT_W   = 8,
    parameter int unsigned CW      = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             mode_signed,
    input  logic             load_m,
    input  logic             load_q,
    input  logic             q_last,
    input  logic [CW-1:0]    idx,
    input  logic [IN_W-1:0]  chunk,
    input  logic             calc,
    input  logic             fixup,
    input  logic             shift,
    output logic [OUT_W-1:0] out_data
);

    localparam int unsigned P_W = calc_p_w(M_WIDTH, Q_WIDTH);
    localparam int unsigned NP  = calc_np(P_W, OUT_W);
    localparam int unsigned EW  = NP * OUT_W;

    logic [M_WIDTH-1:0] m_q, m_next, m_mag;
    logic [Q_WIDTH-1:0] q_q, q_next, q_mag;
    logic [Q_WIDTH-1:0] mplier;
    logic [P_W-1:0]     mcand, acc, res;
    logic               neg;
    logic [EW-1:0]      out_sr, ext;

    // Each operand bit is owned by exactly one chunk index; bits past the
    // operand width in the last chunk have no destination and are dropped.
    for (genvar b = 0; b < M_WIDTH; b++) begin : g_m
        localparam logic [CW-1:0] CH = CW'(b / IN_W);
        assign m_next[b] = (load_m && idx == CH) ? chunk[b % IN_W] : m_q[b];
    end

    for (genvar b = 0; b < Q_WIDTH; b++) begin : g_q
        localparam logic [CW-1:0] CH = CW'(b / IN_W);
        assign q_next[b] = (load_q && idx == CH) ? chunk[b % IN_W] : q_q[b];
    end

    // Magnitudes stay in the operand width: -2^(W-1) maps to 2^(W-1) unsigned.
    always_comb begin
        m_mag = (mode_signed && m_q[M_WIDTH-1])    ? (~m_q + 1'b1)    : m_q;
        q_mag = (mode_signed && q_next[Q_WIDTH-1]) ? (~q_next + 1'b1) : q_next;
        res   = neg ? (~acc + 1'b1) : acc;
        ext   = mode_signed ? EW'(signed'(res)) : EW'(res);
    end

    assign out_data = out_sr[OUT_W-1:0];

    // Operand capture, shift-add iteration, fix-up into the emit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q    <= '0;
            q_q    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            neg    <= 1'b0;
            out_sr <= '0;
        end else begin
            m_q <= m_next;
            q_q <= q_next;
            if (clear) begin
                mcand  <= '0;
                mplier <= '0;
                acc    <= '0;
                neg    <= 1'b0;
                out_sr <= '0;
            end else begin
                if (q_last) begin
                    mcand  <= P_W'(m_mag);
                    mplier <= q_mag;
                    acc    <= '0;
                    neg    <= mode_signed & (m_q[M_WIDTH-1] ^ q_next[Q_WIDTH-1]);
                end
                if (calc) begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                end
                if (fixup) out_sr <= ext;
                if (shift) out_sr <= out_sr >> OUT_W;
            end
        end
    end

endmodule

// File: rtl/mulu_seq_stream.sv
// Streaming sequential shift-add multiplier: chunked operand input, chunked
// product output, per-operation signed mode, backpressure and abort.
module mulu_seq_stream
    import mulu_seq_stream_pkg::*;
#(
    parameter int unsigned M_WIDTH = 7,
    parameter int unsigned Q_WIDTH = 7,
    parameter int unsigned IN_W    = 6,
    parameter int unsigned OUT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ready,
    input  logic             op_signed,
    input  logic             abort,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy
);

    localparam int unsigned P_W     = calc_p_w(M_WIDTH, Q_WIDTH);
    localparam int unsigned NM      = calc_nm(M_WIDTH, IN_W);
    localparam int unsigned NQ      = calc_nq(Q_WIDTH, IN_W);
    localparam int unsigned NP      = calc_np(P_W, OUT_W);
    localparam int unsigned CNT_MAX = max_u(max_u(NM, NQ), max_u(NP, Q_WIDTH));
    localparam int unsigned CW      = clog2(CNT_MAX);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          mode_signed;
    logic          in_xfer, out_xfer, load_m, load_q, q_last, calc_en, fixup_en;

    // Transfer strobes; abort suppresses any coincident transfer.
    always_comb begin
        in_xfer  = in_valid & in_ready & ~abort;
        out_xfer = out_valid & out_ready & ~abort;
        load_m   = in_xfer & (state == LOAD_M);
        load_q   = in_xfer & (state == LOAD_Q);
        q_last   = load_q & (cnt == CW'(NQ - 1));
        calc_en  = (state == CALC) & ~abort;
        fixup_en = (state == FIXUP) & ~abort;
    end

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LOAD_M;
            cnt         <= '0;
            mode_signed <= 1'b0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            busy        <= 1'b0;
        end else if (abort) begin
            state     <= LOAD_M;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                LOAD_M: if (in_valid) begin
                    if (cnt == '0) mode_signed <= op_signed;
                    if (cnt == CW'(NM - 1)) begin
                        state <= LOAD_Q;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LOAD_Q: if (in_valid) begin
                    if (cnt == CW'(NQ - 1)) begin
                        state    <= CALC;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CALC: begin
                    if (cnt == CW'(Q_WIDTH - 1)) begin
                        state <= FIXUP;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FIXUP: begin
                    state     <= EMIT;
                    out_valid <= 1'b1;
                    out_last  <= (NP == 1);
                end
                EMIT: if (out_ready) begin
                    if (cnt == CW'(NP - 1)) begin
                        state     <= LOAD_M;
                        cnt       <= '0;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        cnt      <= cnt + 1'b1;
                        out_last <= (cnt + 1'b1 == CW'(NP - 1));
                    end
                end
                default: state <= LOAD_M;
            endcase
        end
    end

    mulu_seq_datapath #(
        .M_WIDTH(M_WIDTH),
        .Q_WIDTH(Q_WIDTH),
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .CW     (CW)
    ) u_datapath (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (abort),
        .mode_signed(mode_signed),
        .load_m     (load_m),
        .load_q     (load_q),
        .q_last     (q_last),
        .idx        (cnt),
        .chunk      (in_data),
        .calc       (calc_en),
        .fixup      (fixup_en),
        .shift      (out_xfer),
        .out_data   (out_data)
    );

endmodule

// File: tb/tb_mulu_seq_stream.sv
// Directed bench for mulu_seq_stream with a queue scoreboard of product chunks.
module tb_mulu_seq_stream;

    localparam int unsigned M_WIDTH = 7;
    localparam int unsigned Q_WIDTH = 7;
    localparam int unsigned IN_W    = 6;
    localparam int unsigned OUT_W   = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [IN_W-1:0]  in_data = '0;
    logic             in_ready;
    logic             op_signed = 1'b0;
    logic             abort = 1'b0;
    logic             out_valid;
    logic [OUT_W-1:0] out_data;
    logic             out_last;
    logic             out_ready = 1'b0;
    logic             busy;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } exp_t;

    exp_t        sb[$];
    int unsigned checks = 0;
    int unsigned passed = 0;
    int unsigned fails  = 0;

    always #5 clk = ~clk;

    mulu_seq_stream #(
        .M_WIDTH(M_WIDTH),
        .Q_WIDTH(Q_WIDTH),
        .IN_W   (IN_W),
        .OUT_W  (OUT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .op_signed(op_signed),
        .abort    (abort),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_last (out_last),
        .out_ready(out_ready),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [15:0] model(input logic [6:0] m, input logic [6:0] q, input logic s);
        int a, b;
        logic [31:0] p;
        a = (s && m[6]) ? int'(m) - 128 : int'(m);
        b = (s && q[6]) ? int'(q) - 128 : int'(q);
        p = a * b;
        return p[15:0];
    endfunction

    task automatic send_chunk(input logic [5:0] d, input logic s);
        int n = 0;
        in_valid  = 1'b1;
        in_data   = d;
        op_signed = s;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) check("in_ready_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid  = 1'b0;
        op_signed = 1'b0;
    endtask

    // Mode only on the first chunk; later chunks carry the opposite mode and
    // junk above the operand MSB, both of which must be ignored.
    task automatic send_op(input logic [6:0] m, input logic [6:0] q, input logic s, input logic push);
        logic [15:0] p;
        send_chunk(m[5:0], s);
        send_chunk({5'b10110, m[6]}, !s);
        send_chunk(q[5:0], !s);
        send_chunk({5'b01011, q[6]}, !s);
        if (push) begin
            p = model(m, q, s);
            sb.push_back('{d: p[7:0], l: 1'b0});
            sb.push_back('{d: p[15:8], l: 1'b1});
        end
    endtask

    task automatic wait_out(input string tag);
        int lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd8);
    endtask

    task automatic recv(input string tag);
        exp_t e;
        out_ready = 1'b1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_data"}, 32'(out_data), 32'(e.d));
            check({tag, "_last"}, 32'(out_last), 32'(e.l));
            tick();
        end
        out_ready = 1'b0;
        check({tag, "_done_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_done_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_last"}, 32'(out_last), 32'd0);
        check({tag, "_out_data"}, 32'(out_data), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [6:0] rm, rq;
        logic       rs;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;
        tick();

        // Unsigned 127x127 -> 0x3F01
        send_op(7'd127, 7'd127, 1'b0, 1'b1);
        check("calc_busy", 32'(busy), 32'd1);
        check("calc_in_ready", 32'(in_ready), 32'd0);
        wait_out("u127");
        recv("u127");

        // Signed -64 x 3 -> 0x3F40 sign-extended
        send_op(7'h40, 7'h03, 1'b1, 1'b1);
        wait_out("sm64x3");
        recv("sm64x3");

        // Signed -64 x -64 -> 4096
        send_op(7'h40, 7'h40, 1'b1, 1'b1);
        wait_out("sm64xm64");
        recv("sm64xm64");

        // Unsigned 5 x 0
        send_op(7'd5, 7'd0, 1'b0, 1'b1);
        wait_out("u5x0");
        recv("u5x0");

        // Backpressure with in_valid asserted during EMIT
        send_op(7'd127, 7'd127, 1'b0, 1'b1);
        wait_out("bp");
        in_valid = 1'b1;
        in_data  = 6'h3F;
        repeat (5) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data", 32'(out_data), 32'h01);
            check("bp_last", 32'(out_last), 32'd0);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        in_valid = 1'b0;
        recv("bp");

        // Abort on the third CALC cycle
        send_op(7'd3, 7'd3, 1'b0, 1'b0);
        tick();
        tick();
        check("abort_calc_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_calc_in_ready", 32'(in_ready), 32'd1);
        check("abort_calc_busy_after", 32'(busy), 32'd0);
        check("abort_calc_out_valid", 32'(out_valid), 32'd0);
        send_op(7'd5, 7'd6, 1'b0, 1'b1);
        wait_out("u5x6");
        recv("u5x6");

        // Abort coincident with the first output transfer
        send_op(7'd2, 7'd3, 1'b0, 1'b0);
        wait_out("abort_emit");
        out_ready = 1'b1;
        abort     = 1'b1;
        tick();
        abort     = 1'b0;
        out_ready = 1'b0;
        check("abort_emit_out_valid", 32'(out_valid), 32'd0);
        check("abort_emit_in_ready", 32'(in_ready), 32'd1);
        check("abort_emit_busy", 32'(busy), 32'd0);

        // Abort in LOAD_M after a partial operand, coincident with a chunk
        send_chunk(6'h2A, 1'b1);
        in_valid = 1'b1;
        in_data  = 6'h15;
        abort    = 1'b1;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        send_op(7'd7, 7'd9, 1'b0, 1'b1);
        wait_out("u7x9");
        recv("u7x9");

        // Reset mid-EMIT after chunk 0
        send_op(7'd100, 7'd50, 1'b0, 1'b0);
        wait_out("rst_emit");
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_emit");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        send_op(7'h7F, 7'h02, 1'b1, 1'b1);
        wait_out("sm1x2");
        recv("sm1x2");

        // Reset mid-LOAD_Q
        send_chunk(6'h11, 1'b0);
        send_chunk(6'h01, 1'b0);
        send_chunk(6'h22, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_loadq");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        send_op(7'd11, 7'd13, 1'b0, 1'b1);
        wait_out("u11x13");
        recv("u11x13");

        // A few random operations in both modes
        repeat (6) begin
            rm = 7'($urandom);
            rq = 7'($urandom);
            rs = 1'($urandom_range(0, 1));
            send_op(rm, rq, rs, 1'b1);
            wait_out("rand");
            recv("rand");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mulu_seq_stream.md
Name: mulu_seq_stream

Overview:
- Parametrised sequential shift-add multiplier core. It is the successor to the fixed 7x7 unsigned multiplier top.
- Operands arrive as narrow chunks over a valid/ready stream, LSB-chunk first. The product is returned as OUT_W-bit chunks over a second valid/ready stream.
- Adds a per-operation signed/unsigned mode, output backpressure and a synchronous abort.
- Sits behind the TinyTapeout io_in/io_out pin wrapper, which maps pins onto these ports.

Parameters:
- M_WIDTH, 7, multiplicand width (>=2)
- Q_WIDTH, 7, multiplier width (>=2)
- IN_W, 6, input chunk width
- OUT_W, 8, output chunk width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input chunk valid
- in_data  in  IN_W  operand chunk
- in_ready  out  1  core accepts a chunk this cycle
- op_signed  in  1  operation mode, 1 = two's-complement; sampled with the first M chunk
- abort  in  1  synchronous cancel
- out_valid  out  1  product chunk valid
- out_data  out  OUT_W  product chunk
- out_last  out  1  final product chunk
- out_ready  in  1  consumer accepts the chunk
- busy  out  1  high in CALC/FIXUP/EMIT

Behaviour:
- Derived constants:
  - P_W = M_WIDTH + Q_WIDTH
  - NM = ceil(M_WIDTH/IN_W)
  - NQ = ceil(Q_WIDTH/IN_W)
  - NP = ceil(P_W/OUT_W)
- Reset (async, rst_n=0) values:
  - state = LOAD_M, all counters 0, accumulator 0
  - in_ready=1, out_valid=0, out_last=0, out_data=0, busy=0
- A transfer occurs on a rising edge with valid & ready both high.
- LOAD_M:
  - Accepts NM chunks and assembles M LSB-first. Bits beyond M_WIDTH in the last chunk are ignored.
  - op_signed is latched on the first M chunk and held for the whole operation.
  - After NM chunks → LOAD_Q.
- LOAD_Q:
  - Accepts NQ chunks the same way. After the last chunk → CALC.
  - in_ready=1 only in LOAD_M/LOAD_Q.
- CALC:
  - If signed, operands are first replaced by their magnitudes, each held in M_WIDTH/Q_WIDTH unsigned bits so that -2^(W-1) is representable.
  - Runs exactly Q_WIDTH cycles, one multiplier bit per cycle, LSB first: acc += bit ? (M << i) : 0.
  - The P_W-bit accumulator never overflows.
- FIXUP:
  - Always exactly 1 cycle.
  - Negates the accumulator (mod 2^P_W) iff signed and sign(M) != sign(Q). A zero magnitude stays 0.
- Latency: out_valid rises exactly Q_WIDTH+1 cycles after the last Q chunk is accepted, independent of data.
- EMIT:
  - Presents NP chunks LSB-first; out_last=1 on chunk NP-1 only.
  - Unused top bits of the final chunk are zero-filled when unsigned and sign-extended from bit P_W-1 when signed.
  - out_data/out_last are held stable while out_valid & !out_ready.
  - After the final chunk transfers → LOAD_M with out_valid=0 in the next cycle.
  - No new operand is accepted during EMIT.
- abort:
  - Sampled every cycle in any state. Next state is LOAD_M with counters cleared and out_valid=0.
  - abort has priority over any simultaneous in or out transfer; that transfer is discarded and not counted.
  - abort in LOAD_M with partial chunks discards them.
- Reset mid-operation: immediate return to reset values; no partial product is emitted.
- in_valid during CALC/FIXUP/EMIT is ignored (in_ready=0).

Decomposition:
- Shared package holds:
  - state enum {LOAD_M, LOAD_Q, CALC, FIXUP, EMIT}
  - the ceil-div function
  - derived-constant helpers P_W/NM/NQ/NP
  - the chunk counter width function clog2
- Natural sub-module: mulu_seq_datapath. It holds the operand and accumulator registers, magnitude conversion, add-shift and negation.
- The FSM, counters and handshakes stay in mulu_seq_stream.

Test Plan (defaults M=Q=7, IN_W=6, OUT_W=8):
1. Unsigned 127x127:
   - Stimulus: chunks 0x3F, 0x01, 0x3F, 0x01.
   - Response: out 0x01, then 0x3F with out_last; out_valid exactly 8 cycles after the 4th chunk.
2. Signed -64x3:
   - Stimulus: op_signed=1, M chunks 0x00, 0x01; Q chunks 0x03, 0x00.
   - Response: product 0x3F40; out 0x40, then 0xFF with out_last.
3. Signed -64x-64:
   - Stimulus: M and Q both chunks 0x00, 0x01.
   - Response: out 0x00, then 0x10 (4096). Also 0x5 x 0 unsigned → 0x00, 0x00 with the same 8-cycle latency.
4. Backpressure:
   - Stimulus: out_ready=0 for 5 cycles after out_valid.
   - Response: out_data=0x01 stable and in_ready=0 throughout; raising out_ready completes both chunks in 2 cycles.
5. Abort:
   - Stimulus: abort asserted on the 3rd CALC cycle.
   - Response: next cycle in_ready=1, busy=0, out_valid=0; a following 5x6 unsigned op returns 0x1E, 0x00. Also abort coincident with the first out transfer → no chunk consumed, LOAD_M.
6. Reset:
   - Stimulus: rst_n low mid-EMIT (after chunk 0) and mid-LOAD_Q.
   - Response: outputs immediately at reset values; the subsequent op yields the correct product with no stale chunk.
